render_sequencer: RTL and testbench

- Initiator/control end of the ball renderer handshake. Issues one-cycle start strobes for the clear-old, draw-new and black-screen operations and holds matching phase levels while the renderer streams pixels; waits on the renderer's done signals.
- Gates ball physics, edge-detects the scored levels from the ball controller, keeps both scores and declares game over.
- Sits between the frame rate divider, the ball controller/physics and the ball renderer/VGA adapter.

---
 rtl/render_sequencer_if.sv | 38 +++
 rtl/render_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_render_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/render_sequencer_if.sv
// ---------------------------------------------------------------------------
// render_sequencer_if
//   Handshake bundle between the render sequencer (master) and the ball
//   renderer / VGA adapter (slave).
//
//   start_clear / start_draw / start_black : one-cycle operation start strobes
//   phase_clear / phase_draw / phase_black : levels, high while the operation
//                                            is in progress
//   plot                                   : VGA write enable
//   done_clearOld / done_drawNew /
//   done_blackScreen                       : renderer completion pulses
// ---------------------------------------------------------------------------
interface render_sequencer_if;
    logic start_clear;
    logic start_draw;
    logic start_black;
    logic phase_clear;
    logic phase_draw;
    logic phase_black;
    logic plot;
    logic done_clearOld;
    logic done_drawNew;
    logic done_blackScreen;

    modport master (
        output start_clear, start_draw, start_black,
        output phase_clear, phase_draw, phase_black,
        output plot,
        input  done_clearOld, done_drawNew, done_blackScreen
    );

    modport slave (
        input  start_clear, start_draw, start_black,
        input  phase_clear, phase_draw, phase_black,
        input  plot,
        output done_clearOld, done_drawNew, done_blackScreen
    );
endinterface

// File: rtl/render_sequencer.sv
// ---------------------------------------------------------------------------
// render_sequencer
//   Control end of the ball renderer handshake. Sequences black-screen,
//   clear-old and draw-new operations, gates ball physics, captures score
//   events from the ball controller, keeps both scores and declares game over.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   enable            : 0 freezes FSM, counters and outputs (strobes forced 0)
//   frameTick         : one-cycle frame pulse from the frame rate divider
//   lhs_scored        : level, left player scored
//   rhs_scored        : level, right player scored
//   render            : renderer handshake (strobes, phases, plot, dones)
//   physics_en        : enable to ball physics/controller
//   left_score        : left score, saturates at WIN_SCORE
//   right_score       : right score, saturates at WIN_SCORE
//   game_over         : sticky, high in S_OVER
//   frame_overrun     : sticky, frameTick seen while busy clearing/drawing
//   draw_timeout      : sticky, a done wait expired
// ---------------------------------------------------------------------------
module render_sequencer #(
    parameter int WIN_SCORE    = 5,
    parameter int HOLD_FRAMES  = 30,
    parameter int DONE_TIMEOUT = 'd131072
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        frameTick,
    input  logic                        lhs_scored,
    input  logic                        rhs_scored,
    render_sequencer_if.master          render,
    output logic                        physics_en,
    output logic [$clog2(WIN_SCORE):0]  left_score,
    output logic [$clog2(WIN_SCORE):0]  right_score,
    output logic                        game_over,
    output logic                        frame_overrun,
    output logic                        draw_timeout
);

    localparam int SW     = $clog2(WIN_SCORE) + 1;
    localparam int TMR_W  = $clog2(DONE_TIMEOUT + 1);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [2:0] {
        S_BLACK_START,
        S_BLACK,
        S_HOLD,
        S_IDLE,
        S_CLEAR,
        S_DRAW,
        S_OVER
    } state_t;

    state_t state;
    state_t state_nxt;

    // registered outputs and their next values
    logic start_clear, start_draw, start_black;
    logic phase_clear, phase_draw, phase_black;
    logic plot;
    logic start_clear_d, start_draw_d, start_black_d;
    logic phase_clear_d, phase_draw_d, phase_black_d;
    logic plot_d, physics_en_d, game_over_d;

    // score capture and timers
    logic              lhs_scored_p1, rhs_scored_p1;
    logic              lhs_pend, rhs_pend, over_pend;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TMR_W-1:0]  timer;

    // decoded conditions
    logic          lhs_rise, rhs_rise;
    logic          capture_ok, waiting, done_hit, expired, hold_last;
    logic          score_take, over_hit;
    logic [SW-1:0] left_new, right_new;

    assign render.start_clear = start_clear;
    assign render.start_draw  = start_draw;
    assign render.start_black = start_black;
    assign render.phase_clear = phase_clear;
    assign render.phase_draw  = phase_draw;
    assign render.phase_black = phase_black;
    assign render.plot        = plot;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] score, input logic inc);
        if (inc && (score < SW'(WIN_SCORE)))
            return score + SW'(1);
        return score;
    endfunction

    always_comb begin
        lhs_rise   = lhs_scored & ~lhs_scored_p1;
        rhs_rise   = rhs_scored & ~rhs_scored_p1;
        waiting    = (state == S_CLEAR) || (state == S_DRAW) || (state == S_BLACK);
        // score edges during the black screen, its hold and game over are dropped
        capture_ok = !((state == S_BLACK) || (state == S_HOLD) || (state == S_OVER));
        case (state)
            S_CLEAR: done_hit = render.done_clearOld;
            S_DRAW:  done_hit = render.done_drawNew;
            S_BLACK: done_hit = render.done_blackScreen;
            default: done_hit = 1'b0;
        endcase
        // timer counts cycles already spent in the wait state, so this fires
        // on the DONE_TIMEOUT-th cycle; a done in that same cycle wins
        expired    = waiting && !done_hit && (timer == TMR_W'(DONE_TIMEOUT - 1));
        hold_last  = frameTick && (hold_cnt == HOLD_W'(HOLD_FRAMES - 1));
        score_take = (state == S_IDLE) && (lhs_pend || rhs_pend);
        left_new   = sat_inc(left_score, lhs_pend);
        right_new  = sat_inc(right_score, rhs_pend);
        over_hit   = (left_new == SW'(WIN_SCORE)) || (right_new == SW'(WIN_SCORE));
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_BLACK_START;
        else
            state <= state_nxt;
    end

    // ---- FSM: next-state logic ----
    always_comb begin
        state_nxt = state;
        if (enable) begin
            case (state)
                S_BLACK_START: state_nxt = S_BLACK;
                S_BLACK: begin
                    if (done_hit || expired)
                        state_nxt = over_pend ? S_OVER : S_HOLD;
                end
                S_HOLD: begin
                    // the final hold tick is consumed here, not used to start a frame
                    if (hold_last)
                        state_nxt = S_IDLE;
                end
                S_IDLE: begin
                    if (lhs_pend || rhs_pend)
                        state_nxt = S_BLACK_START;
                    else if (frameTick)
                        state_nxt = S_CLEAR;
                end
                S_CLEAR: begin
                    if (done_hit)
                        state_nxt = S_DRAW;
                    else if (expired)
                        state_nxt = S_IDLE;
                end
                S_DRAW: begin
                    if (done_hit || expired)
                        state_nxt = S_IDLE;
                end
                S_OVER:  state_nxt = S_OVER;
                default: state_nxt = S_BLACK_START;
            endcase
        end
    end

    // ---- FSM: output logic (next values of the registered outputs) ----
    always_comb begin
        start_clear_d = enable && (state == S_IDLE)  && (state_nxt == S_CLEAR);
        start_draw_d  = enable && (state == S_CLEAR) && (state_nxt == S_DRAW);
        start_black_d = enable && (state == S_BLACK_START);
        phase_clear_d = (state_nxt == S_CLEAR);
        phase_draw_d  = (state_nxt == S_DRAW);
        phase_black_d = (state_nxt == S_BLACK);
        physics_en_d  = (state_nxt == S_IDLE) || (state_nxt == S_CLEAR) || (state_nxt == S_DRAW);
        game_over_d   = (state_nxt == S_OVER);
        // plot trails the phase by one cycle to line up with the renderer's
        // ROM latency; the write that would follow a sampled done is suppressed
        if (enable)
            plot_d = (phase_clear || phase_draw || phase_black) && !done_hit;
        else
            plot_d = plot;
    end

    // ---- output registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            start_clear <= 1'b0;
            start_draw  <= 1'b0;
            start_black <= 1'b0;
            phase_clear <= 1'b0;
            phase_draw  <= 1'b0;
            phase_black <= 1'b0;
            plot        <= 1'b0;
            physics_en  <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            start_clear <= start_clear_d;
            start_draw  <= start_draw_d;
            start_black <= start_black_d;
            phase_clear <= phase_clear_d;
            phase_draw  <= phase_draw_d;
            phase_black <= phase_black_d;
            plot        <= plot_d;
            physics_en  <= physics_en_d;
            game_over   <= game_over_d;
        end
    end

    // ---- score capture, flags and timers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            lhs_scored_p1 <= 1'b0;
            rhs_scored_p1 <= 1'b0;
            lhs_pend      <= 1'b0;
            rhs_pend      <= 1'b0;
            over_pend     <= 1'b0;
            left_score    <= '0;
            right_score   <= '0;
            frame_overrun <= 1'b0;
            draw_timeout  <= 1'b0;
            hold_cnt      <= '0;
            timer         <= '0;
        end else if (enable) begin
            lhs_scored_p1 <= lhs_scored;
            rhs_scored_p1 <= rhs_scored;
            // consuming clears the latch, but a fresh edge in the same cycle still counts
            lhs_pend <= (lhs_pend && !score_take) || (lhs_rise && capture_ok);
            rhs_pend <= (rhs_pend && !score_take) || (rhs_rise && capture_ok);
            if (score_take) begin
                left_score  <= left_new;
                right_score <= right_new;
                if (over_hit)
                    over_pend <= 1'b1;
            end
            if (frameTick && ((state == S_CLEAR) || (state == S_DRAW)))
                frame_overrun <= 1'b1;
            if (expired)
                draw_timeout <= 1'b1;
            if (state != S_HOLD)
                hold_cnt <= '0;
            else if (frameTick)
                hold_cnt <= hold_cnt + HOLD_W'(1);
            if (state_nxt != state)
                timer <= '0;
            else if (waiting)
                timer <= timer + TMR_W'(1);
        end
    end

endmodule

// File: tb/tb_render_sequencer.sv
// ---------------------------------------------------------------------------
// tb_render_sequencer
//   Directed scenarios followed by randomized stimulus, every cycle compared
//   against a behavioural model of the sequencer's rules.
// ---------------------------------------------------------------------------
module tb_render_sequencer;

    localparam int WIN  = 5;
    localparam int HOLD = 30;
    localparam int TMO  = 64;

    localparam int M_BSTART = 0;
    localparam int M_BLACK  = 1;
    localparam int M_HOLD   = 2;
    localparam int M_IDLE   = 3;
    localparam int M_CLEAR  = 4;
    localparam int M_DRAW   = 5;
    localparam int M_OVER   = 6;

    logic       clk = 1'b0;
    logic       reset, enable, frameTick, lhs_scored, rhs_scored;
    logic       physics_en, game_over, frame_overrun, draw_timeout;
    logic [3:0] left_score, right_score;

    render_sequencer_if rif();

    render_sequencer #(
        .WIN_SCORE(WIN),
        .HOLD_FRAMES(HOLD),
        .DONE_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .frameTick(frameTick),
        .lhs_scored(lhs_scored),
        .rhs_scored(rhs_scored),
        .render(rif),
        .physics_en(physics_en),
        .left_score(left_score),
        .right_score(right_score),
        .game_over(game_over),
        .frame_overrun(frame_overrun),
        .draw_timeout(draw_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model
    int mode, m_left, m_right, m_hold, m_wait;
    bit m_lpend, m_rpend, m_lprev, m_rprev, m_gopend;
    bit e_sc, e_sd, e_sb, e_pc, e_pd, e_pb, e_plot, e_phys, e_go, e_ovr, e_to;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit lr, rr, may_capture, waits, hit, expire, take;
        int nm;
        if (reset) begin
            mode = M_BSTART; m_left = 0; m_right = 0; m_hold = 0; m_wait = 0;
            m_lpend = 0; m_rpend = 0; m_lprev = 0; m_rprev = 0; m_gopend = 0;
            {e_sc, e_sd, e_sb, e_pc, e_pd, e_pb, e_plot, e_phys, e_go, e_ovr, e_to} = '0;
            return;
        end
        if (!enable) begin
            e_sc = 0; e_sd = 0; e_sb = 0;
            return;
        end
        lr = lhs_scored && !m_lprev;
        rr = rhs_scored && !m_rprev;
        may_capture = (mode != M_BLACK) && (mode != M_HOLD) && (mode != M_OVER);
        waits = (mode == M_CLEAR) || (mode == M_DRAW) || (mode == M_BLACK);
        hit = (mode == M_CLEAR && rif.done_clearOld) || (mode == M_DRAW && rif.done_drawNew) ||
              (mode == M_BLACK && rif.done_blackScreen);
        expire = waits && !hit && (m_wait + 1 == TMO);
        take = 0;
        nm = mode;
        e_plot = (e_pc || e_pd || e_pb) && !hit;
        e_sc = 0; e_sd = 0; e_sb = 0;
        if (frameTick && (mode == M_CLEAR || mode == M_DRAW)) e_ovr = 1;
        if (expire) e_to = 1;
        case (mode)
            M_BSTART: begin nm = M_BLACK; e_sb = 1; end
            M_BLACK:  if (hit || expire) nm = m_gopend ? M_OVER : M_HOLD;
            M_HOLD:   if (frameTick) begin
                          m_hold++;
                          if (m_hold == HOLD) nm = M_IDLE;
                      end
            M_IDLE:   if (m_lpend || m_rpend) begin
                          take = 1;
                          if (m_lpend && m_left < WIN) m_left++;
                          if (m_rpend && m_right < WIN) m_right++;
                          if (m_left == WIN || m_right == WIN) m_gopend = 1;
                          nm = M_BSTART;
                      end else if (frameTick) begin
                          nm = M_CLEAR; e_sc = 1;
                      end
            M_CLEAR:  if (hit) begin nm = M_DRAW; e_sd = 1; end
                      else if (expire) nm = M_IDLE;
            M_DRAW:   if (hit || expire) nm = M_IDLE;
            default:  nm = M_OVER;
        endcase
        if (take) begin m_lpend = 0; m_rpend = 0; end
        if (lr && may_capture) m_lpend = 1;
        if (rr && may_capture) m_rpend = 1;
        m_lprev = lhs_scored;
        m_rprev = rhs_scored;
        if (nm != mode) begin m_wait = 0; m_hold = 0; end
        else if (waits) m_wait++;
        mode = nm;
        e_pc = (mode == M_CLEAR);
        e_pd = (mode == M_DRAW);
        e_pb = (mode == M_BLACK);
        e_phys = (mode == M_IDLE) || (mode == M_CLEAR) || (mode == M_DRAW);
        e_go = (mode == M_OVER);
    endtask

    task automatic compare_all();
        check("start_clear", rif.start_clear, e_sc);
        check("start_draw", rif.start_draw, e_sd);
        check("start_black", rif.start_black, e_sb);
        check("phase_clear", rif.phase_clear, e_pc);
        check("phase_draw", rif.phase_draw, e_pd);
        check("phase_black", rif.phase_black, e_pb);
        check("plot", rif.plot, e_plot);
        check("physics_en", physics_en, e_phys);
        check("left_score", left_score, m_left);
        check("right_score", right_score, m_right);
        check("game_over", game_over, e_go);
        check("frame_overrun", frame_overrun, e_ovr);
        check("draw_timeout", draw_timeout, e_to);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic pulse_frame();
        frameTick = 1'b1; tick();
        frameTick = 1'b0; tick();
    endtask

    task automatic hold_out();
        for (int i = 0; i < HOLD; i++) begin
            if (i == HOLD - 1) check("hold_no_physics", physics_en, 0);
            pulse_frame();
        end
        check("hold_done_physics", physics_en, 1);
    endtask

    task automatic black_done();
        rif.done_blackScreen = 1'b1; tick();
        rif.done_blackScreen = 1'b0;
    endtask

    task automatic score(input bit l, input bit r);
        lhs_scored = l; rhs_scored = r; tick();
        lhs_scored = 1'b0; rhs_scored = 1'b0; tick();
        tick();
        check("score_start_black", rif.start_black, 1);
        black_done();
    endtask

    task automatic restart();
        reset = 1'b1; tick();
        reset = 1'b0; tick();
        black_done();
        hold_out();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; frameTick = 1'b0;
        lhs_scored = 1'b0; rhs_scored = 1'b0;
        rif.done_clearOld = 1'b0; rif.done_drawNew = 1'b0; rif.done_blackScreen = 1'b0;

        // reset, black screen, hold of HOLD ticks
        tick();
        check("reset_start_black", rif.start_black, 0);
        check("reset_physics", physics_en, 0);
        reset = 1'b0; tick();
        check("start_black_cycle1", rif.start_black, 1);
        tick(); tick();
        black_done();
        check("hold_phase_black", rif.phase_black, 0);
        hold_out();

        // one frame: clear then draw
        frameTick = 1'b1; tick(); frameTick = 1'b0;
        check("frame_start_clear", rif.start_clear, 1);
        for (int i = 0; i < 4; i++) tick();
        rif.done_clearOld = 1'b1; tick(); rif.done_clearOld = 1'b0;
        check("frame_start_draw", rif.start_draw, 1);
        for (int i = 0; i < 3; i++) tick();
        rif.done_drawNew = 1'b1; tick(); rif.done_drawNew = 1'b0;
        check("frame_back_idle", rif.phase_draw, 0);
        tick();

        // held score level during draw counts once
        frameTick = 1'b1; tick(); frameTick = 1'b0;
        rif.done_clearOld = 1'b1; tick(); rif.done_clearOld = 1'b0;
        lhs_scored = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rif.done_drawNew = (i == 4);
            tick();
        end
        lhs_scored = 1'b0; rif.done_drawNew = 1'b0;
        check("held_left_once", left_score, 1);
        check("held_physics_off", physics_en, 0);
        black_done();
        hold_out();
        check("held_left_still", left_score, 1);

        // climb to 4:4, then simultaneous score ends the game
        score(1'b0, 1'b1); hold_out();
        for (int k = 0; k < 3; k++) begin score(1'b1, 1'b1); hold_out(); end
        check("pre_over_left", left_score, 4);
        check("pre_over_right", right_score, 4);
        score(1'b1, 1'b1);
        check("over_flag", game_over, 1);
        check("over_left", left_score, 5);
        check("over_right", right_score, 5);
        for (int i = 0; i < 5; i++) begin
            pulse_frame();
            check("over_no_clear", rif.start_clear, 0);
        end

        // overrun: extra tick during clear is dropped
        restart();
        frameTick = 1'b1; tick();
        tick(); frameTick = 1'b0;
        check("overrun_flag", frame_overrun, 1);
        rif.done_clearOld = 1'b1; tick(); rif.done_clearOld = 1'b0;
        rif.done_drawNew = 1'b1; tick(); rif.done_drawNew = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("overrun_no_requeue", rif.phase_clear, 0);

        // timeout while waiting for done_clearOld
        frameTick = 1'b1; tick(); frameTick = 1'b0;
        for (int i = 0; i < TMO - 1; i++) tick();
        check("timeout_not_yet", draw_timeout, 0);
        tick();
        check("timeout_flag", draw_timeout, 1);
        check("timeout_idle", physics_en, 1);
        frameTick = 1'b1; tick(); frameTick = 1'b0;
        check("timeout_fresh_clear", rif.start_clear, 1);
        rif.done_clearOld = 1'b1; tick(); rif.done_clearOld = 1'b0;
        rif.done_drawNew = 1'b1; tick(); rif.done_drawNew = 1'b0;

        // enable low freezes the sequencer and masks strobes
        enable = 1'b0; frameTick = 1'b1; tick();
        check("disabled_no_clear", rif.start_clear, 0);
        enable = 1'b1; tick(); frameTick = 1'b0;
        enable = 1'b0; tick();
        check("disabled_strobe_masked", rif.start_clear, 0);
        check("disabled_phase_held", rif.phase_clear, 1);
        enable = 1'b1;
        rif.done_clearOld = 1'b1; tick(); rif.done_clearOld = 1'b0;
        rif.done_drawNew = 1'b1; tick(); rif.done_drawNew = 1'b0;

        // randomized traffic
        reset = 1'b1; tick(); reset = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            reset = ($urandom_range(0, 699) == 0);
            enable = ($urandom_range(0, 19) != 0);
            frameTick = ($urandom_range(0, 5) == 0);
            rif.done_clearOld = ($urandom_range(0, 9) == 0);
            rif.done_drawNew = ($urandom_range(0, 9) == 0);
            rif.done_blackScreen = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 24) == 0) lhs_scored = ~lhs_scored;
            if ($urandom_range(0, 24) == 0) rhs_scored = ~rhs_scored;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
